// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer for the RV64 execute stage.
// A shift-add multiplier and a restoring divider share the hi/lo/opb registers.
// Both retire one operand bit per cycle. Divide-by-zero, signed overflow and
// illegal encodings are resolved at accept time and go straight to DONE.
// out_valid rises on the cycle after DONE is entered. This gives an accept-to-valid
// latency of N+1 for iterated ops and 1 for the shortcut cases.
module mdu_seq #(
    parameter int WIDTH      = 64,
    parameter int WORD_ITERS = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_word,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    input  logic             flush
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORD_ITERS - 1);
    localparam logic [WIDTH-1:0] MIN_FULL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MIN_WORD  = {{(WIDTH-WORD_ITERS+1){1'b1}}, {(WORD_ITERS-1){1'b0}}};

    localparam logic [2:0] OP_MUL  = 3'd0;
    localparam logic [2:0] OP_MULH = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_DIVU = 3'd3;
    localparam logic [2:0] OP_REM  = 3'd4;
    localparam logic [2:0] OP_REMU = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Iteration state: {hi,lo} is the product or the {remainder,quotient} pair.
    // opb holds the multiplicand or the divisor magnitude.
    logic [WIDTH-1:0] hi, lo, opb;
    logic [2:0]       op_q;
    logic             word_q, neg_a_q, neg_b_q;

    logic             op_signed, is_div, is_rem, illegal, div_zero, div_ovf, special;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, load_lo, special_data;
    logic             q_is_div;
    logic [WIDTH-1:0] step_hi, step_lo, final_data;
    logic [WIDTH:0]   mul_sum, div_r;
    logic             div_ge;

    function automatic logic [WIDTH-1:0] sext_word(input logic [WIDTH-1:0] x);
        return {{(WIDTH-WORD_ITERS){x[WORD_ITERS-1]}}, x[WORD_ITERS-1:0]};
    endfunction

    function automatic logic [WIDTH-1:0] ext_operand(input logic [WIDTH-1:0] x,
                                                     input logic word, input logic sgn);
        if (!word)
            return x;
        else if (sgn)
            return sext_word(x);
        else
            return {{(WIDTH-WORD_ITERS){1'b0}}, x[WORD_ITERS-1:0]};
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic signed [WIDTH-1:0] x,
                                                    input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] mulh_result(input logic [WIDTH-1:0] h,
                                                     input logic [WIDTH-1:0] l,
                                                     input logic neg);
        logic signed [2*WIDTH-1:0] p;
        p = {h, l};
        if (neg)
            p = -p;
        return p[2*WIDTH-1:WIDTH];
    endfunction

    // Request decode: operand extension, magnitudes and shortcut detection.
    always_comb begin
        op_signed = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
        is_div    = (in_op >= OP_DIV) && (in_op <= OP_REMU);
        is_rem    = (in_op == OP_REM) || (in_op == OP_REMU);
        illegal   = (in_op > OP_REMU) || ((in_op == OP_MULH) && in_word);
        a_ext     = ext_operand(in_a, in_word, op_signed);
        b_ext     = ext_operand(in_b, in_word, op_signed);
        a_neg     = op_signed && a_ext[WIDTH-1];
        b_neg     = op_signed && b_ext[WIDTH-1];
        a_mag     = apply_sign(a_ext, a_neg);
        b_mag     = apply_sign(b_ext, b_neg);
        div_zero  = is_div && (b_ext == '0);
        div_ovf   = ((in_op == OP_DIV) || (in_op == OP_REM)) && (b_ext == '1) &&
                    (a_ext == (in_word ? MIN_WORD : MIN_FULL));
        special   = illegal || div_zero || div_ovf;
        // Word divides start with the dividend MSB-aligned so the same shifter serves both widths.
        load_lo   = (is_div && in_word) ? (a_mag << WORD_ITERS) : a_mag;
        special_data = '0;
        if (illegal)
            special_data = '0;
        else if (div_zero)
            special_data = is_rem ? (in_word ? sext_word(in_a) : in_a) : '1;
        else if (div_ovf)
            special_data = is_rem ? '0 : a_ext;
    end

    // One multiply or divide iteration, and the sign-corrected result of the final step.
    always_comb begin
        q_is_div = (op_q >= OP_DIV) && (op_q <= OP_REMU);
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        div_r    = {hi, lo[WIDTH-1]};
        div_ge   = div_r >= {1'b0, opb};
        if (q_is_div) begin
            step_hi = div_ge ? WIDTH'(div_r - {1'b0, opb}) : div_r[WIDTH-1:0];
            step_lo = {lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end
        case (op_q)
            OP_MUL:          final_data = word_q ? sext_word(step_lo >> (WIDTH - WORD_ITERS)) : step_lo;
            OP_MULH:         final_data = mulh_result(step_hi, step_lo, neg_a_q ^ neg_b_q);
            OP_DIV, OP_DIVU: final_data = apply_sign(step_lo, neg_a_q ^ neg_b_q);
            OP_REM, OP_REMU: final_data = apply_sign(step_hi, neg_a_q);
            default:         final_data = '0;
        endcase
        if (word_q && (op_q >= OP_DIV))
            final_data = sext_word(final_data);
    end

    // Datapath registers: load on accept, iterate while running.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid && !flush) begin
            hi      <= '0;
            lo      <= load_lo;
            opb     <= b_mag;
            op_q    <= in_op;
            word_q  <= in_word;
            neg_a_q <= a_neg;
            neg_b_q <= b_neg;
        end else if (state == RUN) begin
            hi <= step_hi;
            lo <= step_lo;
        end
    end

    // Sequencer FSM with registered result and valid.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        cnt <= '0;
                        if (special) begin
                            out_data <= special_data;
                            state    <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (cnt == (word_q ? LAST_WORD : LAST_FULL)) begin
                        out_data <= final_data;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // The first DONE cycle only raises valid; no handshake can complete until then.
                    if (flush) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end else if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: the driver pushes reference results, and a monitor
// pops and compares them whenever a result is presented.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic        in_word = 1'b0;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        busy;
    logic        flush = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] data;
        int          lat;
        int          acc;
        logic [2:0]  op;
    } exp_t;
    exp_t q[$];

    bit   rnd_ready = 1'b0;
    logic ready_ctl = 1'b1;
    logic prev_valid = 1'b0;

    mdu_seq #(.WIDTH(64), .WORD_ITERS(32)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_word(in_word), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .flush(flush)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        out_ready = rnd_ready ? 1'($urandom % 2) : ready_ctl;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [63:0] x);
        return {{32{x[31]}}, x[31:0]};
    endfunction

    // Reference result from the arithmetic definition of each op.
    function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b,
                                          output bit special);
        logic               sgn;
        logic [63:0]        x, y, r;
        longint             sx, sy;
        logic signed [127:0] p;
        special = 1'b0;
        if (op >= 3'd6 || (op == 3'd1 && w)) begin
            special = 1'b1;
            return 64'd0;
        end
        sgn = (op == 3'd1) || (op == 3'd2) || (op == 3'd4);
        x = w ? (sgn ? sx32(a) : {32'd0, a[31:0]}) : a;
        y = w ? (sgn ? sx32(b) : {32'd0, b[31:0]}) : b;
        sx = x;
        sy = y;
        r = '0;
        case (op)
            3'd0: r = a * b;
            3'd1: begin
                p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                r = p[127:64];
            end
            3'd2, 3'd4: begin
                if (y == 64'd0) begin
                    special = 1'b1;
                    r = (op == 3'd2) ? 64'hFFFF_FFFF_FFFF_FFFF : x;
                end else if (y == 64'hFFFF_FFFF_FFFF_FFFF &&
                             x == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
                    special = 1'b1;
                    r = (op == 3'd2) ? x : 64'd0;
                end else begin
                    r = (op == 3'd2) ? sx / sy : sx % sy;
                end
            end
            default: begin
                if (y == 64'd0) begin
                    special = 1'b1;
                    r = (op == 3'd3) ? 64'hFFFF_FFFF_FFFF_FFFF : x;
                end else begin
                    r = (op == 3'd3) ? x / y : x % y;
                end
            end
        endcase
        return w ? sx32(r) : r;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom % 6)
            0: return 64'd0;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'($urandom % 20);
            4: return 64'hFFFF_FFFF_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: compare every presented result against the oldest expectation.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got out_valid=1 data=%h, want no result pending", out_data);
                end else begin
                    if (!prev_valid)
                        check($sformatf("latency op=%0d", q[0].op), 64'(cyc - q[0].acc), 64'(q[0].lat));
                    check($sformatf("data op=%0d", q[0].op), out_data, q[0].data);
                    if (out_ready)
                        void'(q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        bit   sp;
        int   n;
        e.data = model(op, w, a, b, sp);
        e.op   = op;
        e.lat  = sp ? 1 : (w ? 33 : 65);
        in_op = op; in_word = w; in_a = a; in_b = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        e.acc = cyc;
        q.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int errs;
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        resetn = 1'b1;
        @(posedge clk); #1;

        // MUL 7 * -3, busy held through the run
        issue(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        errs = 0;
        repeat (64) begin
            if (!busy) errs++;
            @(posedge clk); #1;
        end
        check("busy_during_mul", 64'(errs), 64'd0);
        wait_idle();

        issue(3'd2, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(3'd5, 1'b0, 64'd100, 64'd0);
        issue(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd2);
        issue(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        issue(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        issue(3'd6, 1'b0, 64'd5, 64'd6);
        issue(3'd1, 1'b1, 64'd5, 64'd6);
        wait_idle();

        // Backpressure: DIVU 100/7 held for 10 cycles
        ready_ctl = 1'b0;
        @(posedge clk); #1;
        issue(3'd3, 1'b0, 64'd100, 64'd7);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_seen", 64'(out_valid), 64'd1);
        errs = 0;
        repeat (10) begin
            if (in_ready || !busy || !out_valid) errs++;
            @(posedge clk); #1;
        end
        check("bp_hold", 64'(errs), 64'd0);
        ready_ctl = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        issue(3'd0, 1'b0, 64'd3, 64'd4);
        wait_idle();

        // Flush at counter 20 of a MUL
        issue(3'd0, 1'b0, 64'd5, 64'd6);
        repeat (20) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        void'(q.pop_back());
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        errs = 0;
        repeat (80) begin
            if (out_valid) errs++;
            @(posedge clk); #1;
        end
        check("flush_no_result", 64'(errs), 64'd0);

        // Flush coincident with a request in IDLE
        in_op = 3'd0; in_word = 1'b0; in_a = 64'd9; in_b = 64'd9;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        check("idle_flush_busy", 64'(busy), 64'd0);
        check("idle_flush_in_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of a divide
        issue(3'd2, 1'b0, 64'd12345, 64'd67);
        repeat (10) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_out_data", out_data, 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        issue(3'd0, 1'b1, 64'h1_0000_0003, 64'd5);
        wait_idle();

        // Randomized ops with random consumer backpressure
        rnd_ready = 1'b1;
        repeat (40) begin
            logic [2:0]  op;
            logic        w;
            logic [63:0] a, b;
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom % 2);
            a  = pick();
            b  = pick();
            issue(op, w, a, b);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the RV64 execute stage.
- Sits beside the single-cycle ALU. Accepts one M-extension operation per handshake, runs a shared shift-add multiplier or restoring divider one bit per cycle, and returns a 64-bit result.
- Drives a stall toward the pipeline controller while busy. Accepts a flush from the branch/exception logic.

Parameters:
- WIDTH, 64, operand/result width (XLEN).
- WORD_ITERS, 32, iterations for *W ops.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- in_valid  in  1  request valid
- in_ready  out  1  sequencer can accept
- in_op  in  3  0 MUL, 1 MULH, 2 DIV, 3 DIVU, 4 REM, 5 REMU; 6–7 illegal
- in_word  in  1  *W variant (MULW/DIVW/...); MULH with word=1 is illegal
- in_a  in  WIDTH  rs1 value (u64)
- in_b  in  WIDTH  rs2 value (u64)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result (u64)
- busy  out  1  stall request to pipeline (state != IDLE)
- flush  in  1  abandon current operation

Behaviour:
- Reset: clk edge with resetn=0 puts the FSM in IDLE, counter=0, out_valid=0, out_data=0, busy=0. in_ready=1 after reset. Reset overrides flush and handshakes in the same cycle.
- States:
  - IDLE: in_ready=1. If in_valid && !flush, latch operands and op, then go to RUN. Special cases go straight to DONE instead.
  - RUN: one iteration per cycle. Counter runs 0..N-1, with N = WIDTH (or WORD_ITERS if in_word). After iteration N-1, go to DONE.
  - DONE: out_valid=1 and out_data stable. If out_ready, go to IDLE. in_ready=0 in DONE; no accept on the same edge as out handshake.
- Latency: accept at edge k → out_valid high from edge k+N+1 (MUL: 65, MULW: 33). Special cases: out_valid from edge k+1.
- Word ops:
  - Operands are the low 32 bits, sign-extended (signed ops) or zero-extended (unsigned ops).
  - Result is bits [31:0], sign-extended to 64.
- Arithmetic:
  - MUL returns the low WIDTH bits.
  - MULH returns the high WIDTH bits of the signed×signed 128-bit product. Operands are converted to magnitude and the sign is corrected at the end.
  - DIV/REM are signed: the quotient truncates toward zero and the remainder takes the dividend's sign.
  - DIVU/REMU are unsigned.
- Special cases (resolved in IDLE, no RUN):
  - Divide by zero: quotient = all ones; remainder = dividend (word variant sign-extended).
  - Signed overflow (most-negative / −1, at the operative width): quotient = dividend; remainder = 0.
- Illegal op (6–7, or MULH with word=1): accepted, goes directly to DONE with out_data=0.
- Flush:
  - In IDLE with in_valid: no accept.
  - In RUN or DONE: next state IDLE, out_valid=0 the next cycle. Any pending result is discarded and never presented.
  - Flush in DONE takes priority over out_ready.
- Backpressure: in DONE with out_ready=0, hold out_data/out_valid indefinitely. busy stays 1.
- out_data is registered. It holds its last value in IDLE/RUN; it is don't-care when out_valid=0 but must not glitch within DONE.

Test Plan:
- MUL a=7, b=−3 (0xFFFF_FFFF_FFFF_FFFD) → out_data=0xFFFF_FFFF_FFFF_FFEB; out_valid exactly 65 cycles after accept; busy high throughout.
- DIVW a=0x0000_0000_8000_0000, b=0xFFFF_FFFF_FFFF_FFFF → overflow path; out_valid at +1 cycle; out_data=0xFFFF_FFFF_8000_0000. REMU a=100, b=0 → out_data=100 at +1.
- MULH a=0x8000_0000_0000_0000, b=2 → out_data=0xFFFF_FFFF_FFFF_FFFF. DIV a=−7, b=2 → −3; REM a=−7, b=2 → −1.
- Backpressure: DIVU 100/7, out_ready=0 for 10 cycles after out_valid → out_data=14 held stable; in_ready=0. Raise out_ready → IDLE next cycle; new request accepted the following cycle.
- Flush at RUN counter=20 → out_valid never asserts for that op; in_ready=1 next cycle. Flush coincident with in_valid in IDLE → no accept.
- Reset (resetn=0) mid-RUN → next cycle IDLE, busy=0, out_valid=0, out_data=0; then MULW a=0x1_0000_0003, b=5 → 15 after 33 cycles.
